// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Data-memory request/acknowledge bus between the memory-stage access unit
// (master) and the data memory (slave).
//
// Signals:
//   dmem_req    master->slave  request valid, held until dmem_ack
//   dmem_we     master->slave  1 = write, 0 = read
//   dmem_addr   master->slave  word-aligned byte address
//   dmem_be     master->slave  byte enables, lane i = bits [8i+7:8i]
//   dmem_wdata  master->slave  lane-replicated store data
//   dmem_ack    slave->master  one-cycle completion strobe
//   dmem_rdata  slave->master  read word, valid with dmem_ack on reads
// -----------------------------------------------------------------------------
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Memory stage of the pipeline. Consumes the EX/MEM register, runs one
// request/acknowledge transaction per aligned load/store, freezes EX/MEM
// with stall_hold while the access is in flight, and presents registered
// write-back values (one wb_write pulse per instruction at most).
//
// Parameters:
//   TIMEOUT           cycles in BUSY without dmem_ack before abort (1..255)
//
// Ports:
//   clk               clock, all state on rising edge
//   reset             asynchronous active-low reset
//   is_write_in       instruction writes register_d_in
//   is_load_in        load op
//   is_store_in       store op
//   mem_size_in       00 byte, 01 half, 10/11 word
//   load_unsigned_in  zero-extend (1) / sign-extend (0) sub-word loads
//   alu_result_in     effective address, or result for non-memory ops
//   store_data_in     store source, low-aligned
//   register_d_in     destination register
//   stall_hold        combinational, freezes EX/MEM while high
//   dmem              data-memory bus (master side)
//   wb_write/wb_rd/wb_data  registered write-back
//   misalign_err      one-cycle pulse, misaligned access dropped
//   bus_err           one-cycle pulse, access aborted on timeout
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     is_write_in,
  input  logic                     is_load_in,
  input  logic                     is_store_in,
  input  logic [1:0]               mem_size_in,
  input  logic                     load_unsigned_in,
  input  logic [31:0]              alu_result_in,
  input  logic [31:0]              store_data_in,
  input  logic [4:0]               register_d_in,
  output logic                     stall_hold,
  mem_access_unit_if.master        dmem,
  output logic                     wb_write,
  output logic [4:0]               wb_rd,
  output logic [31:0]              wb_data,
  output logic                     misalign_err,
  output logic                     bus_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  // Fields captured when an aligned access is accepted; held stable in BUSY.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        is_write;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [1:0]  lane;
  } req_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic        wb_write_q, wb_write_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;
  logic        stall_c;

  logic        mem_op;
  logic        misaligned;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] shifted;
  logic [31:0] load_val;

  assign mem_op     = is_load_in | is_store_in;
  assign misaligned = ((mem_size_in == 2'b01) && alu_result_in[0]) ||
                      (mem_size_in[1] && (alu_result_in[1:0] != 2'b00));

  // Store lane steering: data replicated across lanes, enables select them.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = store_data_in;
    case (mem_size_in)
      2'b00: begin
        st_be    = 4'b0001 << alu_result_in[1:0];
        st_wdata = {4{store_data_in[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << alu_result_in[1:0];
        st_wdata = {2{store_data_in[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = store_data_in;
      end
    endcase
  end

  // Load lane extraction and extension from the latched size/lane.
  assign shifted = dmem.dmem_rdata >> {req_q.lane, 3'b000};
  always_comb begin
    load_val = dmem.dmem_rdata;
    case (req_q.size)
      2'b00:   load_val = {{24{~req_q.is_unsigned & shifted[7]}},  shifted[7:0]};
      2'b01:   load_val = {{16{~req_q.is_unsigned & shifted[15]}}, shifted[15:0]};
      default: load_val = dmem.dmem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    wb_write_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    stall_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!mem_op) begin
          wb_write_d = is_write_in;
          wb_rd_d    = register_d_in;
          wb_data_d  = alu_result_in;
        end else if (misaligned) begin
          misalign_d = 1'b1;
        end else begin
          stall_c           = 1'b1;
          req_d.we          = is_store_in;
          req_d.addr        = {alu_result_in[31:2], 2'b00};
          // Reads always fetch the whole word; lane selection happens on return.
          req_d.be          = is_store_in ? st_be : 4'b1111;
          req_d.wdata       = is_store_in ? st_wdata : 32'h0;
          req_d.rd          = register_d_in;
          req_d.is_write    = is_write_in;
          req_d.size        = mem_size_in;
          req_d.is_unsigned = load_unsigned_in;
          req_d.lane        = alu_result_in[1:0];
          cnt_d             = 8'd0;
          state_d           = S_BUSY;
        end
      end
      S_BUSY: begin
        stall_c = 1'b1;
        // Ack takes priority over a coincident timeout.
        if (dmem.dmem_ack) begin
          state_d = S_DONE;
          if (!req_q.we) begin
            wb_write_d = req_q.is_write;
            wb_rd_d    = req_q.rd;
            wb_data_d  = load_val;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_DONE;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        // EX/MEM advances on this edge; inputs still show the finished op.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      req_q      <= '0;
      wb_write_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'h0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      wb_write_q <= wb_write_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Gate with reset so every output reads 0 while reset is held.
  assign stall_hold = reset & stall_c;

  // Bus fields are driven only while a request is outstanding.
  assign dmem.dmem_req   = (state_q == S_BUSY);
  assign dmem.dmem_we    = (state_q == S_BUSY) & req_q.we;
  assign dmem.dmem_addr  = (state_q == S_BUSY) ? req_q.addr  : 32'h0;
  assign dmem.dmem_be    = (state_q == S_BUSY) ? req_q.be    : 4'h0;
  assign dmem.dmem_wdata = (state_q == S_BUSY) ? req_q.wdata : 32'h0;

  assign wb_write     = wb_write_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign misalign_err = misalign_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Self-checking bench for mem_access_unit (TIMEOUT = 4). Directed cases plus
// randomized operations compared against a behavioural model computed from
// the access rules with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        is_write_in, is_load_in, is_store_in, load_unsigned_in;
  logic [1:0]  mem_size_in;
  logic [31:0] alu_result_in, store_data_in;
  logic [4:0]  register_d_in;
  logic        stall_hold, wb_write, misalign_err, bus_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks   = 0;
  int failures = 0;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk              (clk),
    .reset            (reset),
    .is_write_in      (is_write_in),
    .is_load_in       (is_load_in),
    .is_store_in      (is_store_in),
    .mem_size_in      (mem_size_in),
    .load_unsigned_in (load_unsigned_in),
    .alu_result_in    (alu_result_in),
    .store_data_in    (store_data_in),
    .register_d_in    (register_d_in),
    .stall_hold       (stall_hold),
    .dmem             (bus),
    .wb_write         (wb_write),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .misalign_err     (misalign_err),
    .bus_err          (bus_err)
  );

  always #5 clk = ~clk;

  task automatic drive_idle();
    is_write_in      = 1'b0;
    is_load_in       = 1'b0;
    is_store_in      = 1'b0;
    mem_size_in      = 2'b00;
    load_unsigned_in = 1'b0;
    alu_result_in    = 32'h0;
    store_data_in    = 32'h0;
    register_d_in    = 5'd0;
  endtask

  // Runs one instruction through the unit and checks it against the model.
  // ack_delay: index of the BUSY cycle that gets dmem_ack (-1 = never).
  // tail=0 lets the next op follow immediately (aligned memory ops only).
  task automatic do_op(input string name, input logic ld, input logic st,
                       input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] sd,
                       input logic [4:0] rd, input int ack_delay,
                       input logic [31:0] rword, input logic tail);
    int n, a;
    bit memop, mis, acked, released;
    int exp_stall, exp_req, exp_wb, exp_mis, exp_berr;
    int stall_n, req_n, wb_n, mis_n, berr_n, bus_bad;
    logic [31:0] exp_addr, exp_wdata, exp_data, mask;
    logic [3:0]  exp_be;
    logic [4:0]  got_rd;
    logic [31:0] got_data, bad_addr, bad_wdata;
    logic [3:0]  bad_be;
    logic        bad_we;

    // ---- behavioural model ----
    n        = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    a        = int'(addr % 4);
    memop    = ld | st;
    mis      = memop && ((addr % n) != 0);
    acked    = memop && !mis && (ack_delay >= 0) && (ack_delay < TO);
    exp_addr = addr - 32'(a);
    exp_be   = st ? 4'((((32'd1 << n) - 32'd1) << a)) : 4'hF;
    exp_wdata = 32'h0;
    for (int i = 0; i < 4; i++)
      exp_wdata |= ((sd >> (8 * (i % n))) & 32'hFF) << (8 * i);
    if (!memop) begin
      exp_data = addr;
    end else begin
      mask     = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
      exp_data = (rword >> (8 * a)) & mask;
      if (!uns && n < 4 && exp_data[8*n-1]) exp_data |= ~mask;
    end
    exp_wb    = memop ? int'(acked && !st && wr) : int'(wr);
    exp_stall = (memop && !mis) ? 1 + (acked ? ack_delay + 1 : TO) : 0;
    exp_req   = (exp_stall > 0) ? exp_stall - 1 : 0;
    exp_mis   = int'(mis);
    exp_berr  = int'(memop && !mis && !acked);

    // ---- stimulus ----
    is_write_in = wr; is_load_in = ld; is_store_in = st; mem_size_in = sz;
    load_unsigned_in = uns; alu_result_in = addr; store_data_in = sd;
    register_d_in = rd;
    stall_n = 0; req_n = 0; wb_n = 0; mis_n = 0; berr_n = 0; bus_bad = 0;
    got_rd = '0; got_data = '0; released = 0;
    bad_addr = '0; bad_be = '0; bad_we = 0; bad_wdata = '0;
    for (int c = 0; c < 40 && !released; c++) begin
      #1;
      if (wb_write) begin wb_n++; got_rd = wb_rd; got_data = wb_data; end
      if (misalign_err) mis_n++;
      if (bus_err) berr_n++;
      if (stall_hold) stall_n++;
      if (bus.dmem_req) begin
        if (bus.dmem_addr !== exp_addr || bus.dmem_be !== exp_be ||
            bus.dmem_we !== st || (st && bus.dmem_wdata !== exp_wdata)) begin
          bus_bad++;
          bad_addr = bus.dmem_addr; bad_be = bus.dmem_be;
          bad_we = bus.dmem_we; bad_wdata = bus.dmem_wdata;
        end
        bus.dmem_ack   = (req_n == ack_delay);
        bus.dmem_rdata = rword;
        req_n++;
      end else begin
        // Stray acks with no request outstanding must be ignored.
        bus.dmem_ack   = 1'($urandom_range(0, 1));
        bus.dmem_rdata = $urandom;
      end
      released = !stall_hold;
      @(posedge clk); @(negedge clk);
      bus.dmem_ack = 1'b0;
    end
    if (tail) begin
      drive_idle();
      for (int c = 0; c < 3; c++) begin
        #1;
        if (wb_write) begin wb_n++; got_rd = wb_rd; got_data = wb_data; end
        if (misalign_err) mis_n++;
        if (bus_err) berr_n++;
        bus.dmem_ack = 1'($urandom_range(0, 1));
        @(posedge clk); @(negedge clk);
        bus.dmem_ack = 1'b0;
      end
    end

    $display("txn %s ld=%0b st=%0b sz=%0d addr=%h stall=%0d req=%0d wb=%0d mis=%0d berr=%0d",
             name, ld, st, sz, addr, stall_n, req_n, wb_n, mis_n, berr_n);

    // ---- comparisons ----
    checks++;
    if (stall_n !== exp_stall) begin
      failures++; $display("FAIL %s stall_cycles got=%0d exp=%0d", name, stall_n, exp_stall);
    end
    checks++;
    if (req_n !== exp_req) begin
      failures++; $display("FAIL %s req_cycles got=%0d exp=%0d", name, req_n, exp_req);
    end
    checks++;
    if (wb_n !== exp_wb) begin
      failures++; $display("FAIL %s wb_pulses got=%0d exp=%0d", name, wb_n, exp_wb);
    end
    checks++;
    if (mis_n !== exp_mis) begin
      failures++; $display("FAIL %s misalign_pulses got=%0d exp=%0d", name, mis_n, exp_mis);
    end
    checks++;
    if (berr_n !== exp_berr) begin
      failures++; $display("FAIL %s bus_err_pulses got=%0d exp=%0d", name, berr_n, exp_berr);
    end
    if (exp_req > 0) begin
      checks++;
      if (bus_bad != 0) begin
        failures++;
        $display("FAIL %s bus_fields got addr=%h be=%b we=%0b wdata=%h exp addr=%h be=%b we=%0b wdata=%h",
                 name, bad_addr, bad_be, bad_we, bad_wdata, exp_addr, exp_be, st, exp_wdata);
      end
    end
    if (exp_wb > 0 && wb_n > 0) begin
      checks++;
      if (got_rd !== rd) begin
        failures++; $display("FAIL %s wb_rd got=%0d exp=%0d", name, got_rd, rd);
      end
      checks++;
      if (got_data !== exp_data) begin
        failures++; $display("FAIL %s wb_data got=%h exp=%h", name, got_data, exp_data);
      end
    end
  endtask

  task automatic test_reset();
    drive_idle();
    // A pending aligned load must not raise stall_hold while in reset.
    is_load_in = 1'b1; mem_size_in = 2'b10; alu_result_in = 32'h40;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({stall_hold, bus.dmem_req, bus.dmem_we, wb_write, misalign_err, bus_err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got stall=%b req=%b we=%b wbw=%b mis=%b berr=%b exp all 0",
               stall_hold, bus.dmem_req, bus.dmem_we, wb_write, misalign_err, bus_err);
    end
    checks++;
    if ({bus.dmem_addr, bus.dmem_be, bus.dmem_wdata, wb_rd, wb_data} !== '0) begin
      failures++;
      $display("FAIL reset_data got addr=%h be=%b wdata=%h rd=%0d data=%h exp all 0",
               bus.dmem_addr, bus.dmem_be, bus.dmem_wdata, wb_rd, wb_data);
    end
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    bit seen;
    is_load_in = 1'b1; is_write_in = 1'b1; mem_size_in = 2'b10;
    alu_result_in = 32'h0000_0300; register_d_in = 5'd9;
    seen = 0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(posedge clk); @(negedge clk); #1;
      seen = bus.dmem_req;
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL async_reset_setup dmem_req got=0 exp=1");
    end
    #2;
    reset = 1'b0;   // mid-cycle, away from any clock edge
    #1;
    checks++;
    if (bus.dmem_req !== 1'b0 || stall_hold !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_req got req=%b stall=%b exp 0 0", bus.dmem_req, stall_hold);
    end
    checks++;
    if ({wb_write, misalign_err, bus_err, bus.dmem_addr, bus.dmem_be} !== '0) begin
      failures++;
      $display("FAIL async_reset_outs got wbw=%b mis=%b berr=%b addr=%h be=%b exp all 0",
               wb_write, misalign_err, bus_err, bus.dmem_addr, bus.dmem_be);
    end
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_op("alu_rd5",         0, 0, 1, 2'b10, 0, 32'h0000_1234, 32'h0, 5'd5, -1, 32'h0, 1);
    do_op("load_byte_s",     1, 0, 1, 2'b00, 0, 32'h0000_0103, 32'h0, 5'd7,  1, 32'h80FF_0011, 1);
    do_op("store_half",      0, 1, 0, 2'b01, 0, 32'h0000_0202, 32'h0000_ABCD, 5'd0, 0, 32'h0, 1);
    do_op("load_word_mis",   1, 0, 1, 2'b10, 0, 32'h0000_0006, 32'h0, 5'd3, 0, 32'h0, 1);
    do_op("load_half_u",     1, 0, 1, 2'b01, 1, 32'h0000_0012, 32'h0, 5'd8, 2, 32'hF00D_BEEF, 1);
    do_op("load_size11",     1, 0, 1, 2'b11, 0, 32'h0000_0020, 32'h0, 5'd2, 0, 32'hCAFE_1234, 1);
  endtask

  task automatic test_timeout();
    do_op("load_timeout",    1, 0, 1, 2'b10, 0, 32'h0000_0400, 32'h0, 5'd4, -1, 32'h0, 1);
    // Ack on the last allowed cycle must win over the timeout.
    do_op("load_ack_at_to",  1, 0, 1, 2'b00, 1, 32'h0000_0401, 32'h0, 5'd6, TO - 1, 32'h1234_8056, 1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      int kind, dly;
      logic [1:0] sz;
      logic [31:0] addr;
      kind = $urandom_range(0, 2);
      sz   = 2'($urandom_range(0, 3));
      addr = {$urandom_range(0, 255), 8'h0} | 32'($urandom_range(0, 255));
      dly  = $urandom_range(0, 6) - 1;
      do_op("rand", kind == 1, kind == 2, 1'($urandom_range(0, 1)), sz,
            1'($urandom_range(0, 1)), addr, $urandom, 5'($urandom_range(0, 31)),
            dly, $urandom, 1);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 30; k++) begin
      int n;
      logic [1:0] sz;
      logic [31:0] addr;
      bit st;
      sz   = 2'($urandom_range(0, 3));
      n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      addr = 32'($urandom_range(0, 4095));
      addr = addr - (addr % n);
      st   = 1'($urandom_range(0, 1));
      do_op("b2b", !st, st, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
            addr, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 4), $urandom, 0);
    end
    drive_idle();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    drive_idle();
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'h0;
    reset          = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_timeout();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
